// File: rtl/id_stage.sv
// id_stage: RV32I instruction-decode stage. Holds the IF/ID register,
// decodes fields and immediates, reads the 32x32 register file, and
// latches an ID/EX bundle for execute. Detects load-use hazards
// (stalls fetch, inserts one bubble) and honours branch flushes.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   inst_in, pc_in     instruction and word-index PC from fetch
//   flush              branch taken in execute
//   wb_en/wb_rd/wb_data register-file write from writeback
//   stall_out          hold fetch (combinational)
//   ex_*               ID/EX register contents
//
// Build option: define ID_WB_BYPASS_EN to make a same-cycle writeback
// visible to the register read (write-through). Without it the read
// returns the pre-write value and execute forwarding covers that case.
module id_stage #(
   parameter int XLEN     = 32,
   parameter int NUM_REGS = 32,
   parameter int PC_W     = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] inst_in,
   input  logic [PC_W-1:0] pc_in,
   input  logic            flush,
   input  logic            wb_en,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            stall_out,
   output logic            ex_valid,
   output logic [PC_W-1:0] ex_pc,
   output logic [6:0]      ex_opcode,
   output logic [2:0]      ex_funct3,
   output logic            ex_funct7b5,
   output logic [4:0]      ex_rs1,
   output logic [4:0]      ex_rs2,
   output logic [4:0]      ex_rd,
   output logic [XLEN-1:0] ex_rs1_data,
   output logic [XLEN-1:0] ex_rs2_data,
   output logic [XLEN-1:0] ex_imm,
   output logic            ex_mem_read
);

   localparam logic [6:0] OP_IMM  = 7'b0010011;
   localparam logic [6:0] OP_LOAD = 7'b0000011;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_STORE= 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_LUI  = 7'b0110111;
   localparam logic [6:0] OP_AUIPC= 7'b0010111;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_REG  = 7'b0110011;

   typedef struct packed {
      logic            valid;
      logic [PC_W-1:0] pc;
      logic [6:0]      opcode;
      logic [2:0]      funct3;
      logic            funct7b5;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic            mem_read;
   } id_ex_t;

   logic            ifid_valid;
   logic [XLEN-1:0] ifid_inst;
   logic [PC_W-1:0] ifid_pc;

   logic [XLEN-1:0] rf [NUM_REGS];

   id_ex_t ex_q;
   id_ex_t ex_d;

   logic [6:0]      opcode;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic [XLEN-1:0] imm;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic            is_i, is_s, is_b, is_u, is_j;
   logic            uses_rs2;
   logic            hazard;

   assign opcode = ifid_inst[6:0];
   assign rs1    = ifid_inst[19:15];
   assign rs2    = ifid_inst[24:20];

   assign is_i = (opcode == OP_IMM) || (opcode == OP_LOAD)
              || (opcode == OP_JALR);
   assign is_s = (opcode == OP_STORE);
   assign is_b = (opcode == OP_BR);
   assign is_u = (opcode == OP_LUI) || (opcode == OP_AUIPC);
   assign is_j = (opcode == OP_JAL);

   always_comb begin
      imm = '0;
      unique case (1'b1)
         is_i: imm = {{(XLEN-12){ifid_inst[31]}}, ifid_inst[31:20]};
         is_s: imm = {{(XLEN-12){ifid_inst[31]}},
                      ifid_inst[31:25], ifid_inst[11:7]};
         is_b: imm = {{(XLEN-12){ifid_inst[31]}}, ifid_inst[7],
                      ifid_inst[30:25], ifid_inst[11:8], 1'b0};
         is_u: imm = {{(XLEN-31){ifid_inst[31]}},
                      ifid_inst[30:12], 12'b0};
         is_j: imm = {{(XLEN-20){ifid_inst[31]}}, ifid_inst[19:12],
                      ifid_inst[20], ifid_inst[30:21], 1'b0};
         default: imm = '0;
      endcase
   end

   always_comb begin
      rs1_data = '0;
      rs2_data = '0;
      if (rs1 != 5'd0) rs1_data = rf[rs1];
      if (rs2 != 5'd0) rs2_data = rf[rs2];
`ifdef ID_WB_BYPASS_EN
      if (wb_en && wb_rd != 5'd0 && wb_rd == rs1) rs1_data = wb_data;
      if (wb_en && wb_rd != 5'd0 && wb_rd == rs2) rs2_data = wb_data;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
      end else if (wb_en && wb_rd != 5'd0) begin
         rf[wb_rd] <= wb_data;
      end
   end

   // rs1 is compared for every opcode; rs2 only where it is a source.
   assign uses_rs2 = (opcode == OP_REG) || (opcode == OP_STORE)
                  || (opcode == OP_BR);

   assign hazard = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0)
                && ifid_valid
                && ((ex_q.rd == rs1) || (uses_rs2 && ex_q.rd == rs2));

   assign stall_out = hazard && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ifid_valid <= 1'b0;
         ifid_inst  <= '0;
         ifid_pc    <= '0;
      end else if (flush) begin
         ifid_valid <= 1'b0;
      end else if (!stall_out) begin
         ifid_valid <= 1'b1;
         ifid_inst  <= inst_in;
         ifid_pc    <= pc_in;
      end
   end

   always_comb begin
      ex_d          = '0;
      ex_d.valid    = 1'b1;
      ex_d.pc       = ifid_pc;
      ex_d.opcode   = opcode;
      ex_d.funct3   = ifid_inst[14:12];
      ex_d.funct7b5 = ifid_inst[30];
      ex_d.rs1      = rs1;
      ex_d.rs2      = rs2;
      ex_d.rd       = ifid_inst[11:7];
      ex_d.rs1_data = rs1_data;
      ex_d.rs2_data = rs2_data;
      ex_d.imm      = imm;
      ex_d.mem_read = (opcode == OP_LOAD);
   end

   // Stall, flush and an empty IF/ID all hand execute a zeroed bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q <= '0;
      end else if (flush || stall_out || !ifid_valid) begin
         ex_q <= '0;
      end else begin
         ex_q <= ex_d;
      end
   end

   assign ex_valid    = ex_q.valid;
   assign ex_pc       = ex_q.pc;
   assign ex_opcode   = ex_q.opcode;
   assign ex_funct3   = ex_q.funct3;
   assign ex_funct7b5 = ex_q.funct7b5;
   assign ex_rs1      = ex_q.rs1;
   assign ex_rs2      = ex_q.rs2;
   assign ex_rd       = ex_q.rd;
   assign ex_rs1_data = ex_q.rs1_data;
   assign ex_rs2_data = ex_q.rs2_data;
   assign ex_imm      = ex_q.imm;
   assign ex_mem_read = ex_q.mem_read;

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage of the RV32I pipeline, directly downstream of the fetch stage.
- Captures the fetched instruction and its PC in an IF/ID register, decodes fields and immediates, and reads the 32x32 register file.
- Latches the results into an ID/EX register that feeds execute.
- Owns load-use hazard detection: stalls fetch and inserts bubbles. Honours branch flushes from execute.

Parameters:
- XLEN, 32, datapath and register width.
- NUM_REGS, 32, register-file depth; x0 is hardwired to zero.
- PC_W, 32, PC width; the PC is a word index, so fetch increments it by 1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- inst_in  in  XLEN  instruction from fetch
- pc_in  in  PC_W  PC of inst_in
- flush  in  1  branch taken in execute; same signal that redirects fetch
- wb_en  in  1  register-file write enable from writeback
- wb_rd  in  5  writeback destination
- wb_data  in  XLEN  writeback value
- stall_out  out  1  hold fetch PC/instruction (combinational)
- ex_valid  out  1  ID/EX entry valid
- ex_pc  out  PC_W  PC of ID/EX entry
- ex_opcode  out  7  inst[6:0]
- ex_funct3  out  3  inst[14:12]
- ex_funct7b5  out  1  inst[30]
- ex_rs1, ex_rs2, ex_rd  out  5 each  register indices
- ex_rs1_data, ex_rs2_data  out  XLEN  operand values
- ex_imm  out  XLEN  sign-extended immediate
- ex_mem_read  out  1  entry is a load (opcode 0000011)

Behaviour:
- Reset (rst_n low, asynchronous): all ex_* outputs 0, IF/ID valid 0, IF/ID inst/pc 0, all registers 0. First edge after release loads IF/ID with valid=1.
- Latency: inst_in sampled at edge k appears on ex_* after edge k+1 (1 cycle in IF/ID, 1 in ID/EX).
- Immediate generation by opcode:
  - I-type (0010011, 0000011, 1100111): sext inst[31:20]
  - S-type (0100011): sext {inst[31:25], inst[11:7]}
  - B-type (1100011): sext {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}
  - U-type (0110111, 0010111): {inst[31:12], 12'b0}
  - J-type (1101111): sext {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}
  - Other opcodes: imm = 0, still passed with valid=1.
- Register file: reads are combinational from IF/ID rs1/rs2. Writes occur on the clk edge when wb_en=1 and wb_rd!=0. Writes to x0 are ignored; x0 always reads 0.
- Load-use hazard: stall_out=1 when all of the following hold:
  - ex_valid=1, ex_mem_read=1 and ex_rd!=0;
  - IF/ID valid=1;
  - ex_rd equals IF/ID rs1, or equals rs2 for opcodes that use rs2 (0110011, 0100011, 1100011).
- While stalled: IF/ID holds its contents; ID/EX loads a bubble (ex_valid=0, all other ex_* 0). Stall lasts exactly one cycle per hazard.
- Flush: on an edge with flush=1, IF/ID valid and ID/EX valid are cleared; other fields don't-care. Flush overrides stall (stall_out forced 0 while flush=1).
- Invalid IF/ID entry: propagates as a bubble; never raises stall_out.
- Reset mid-operation: immediate return to reset values; a pending stall is dropped.

Optional Feature:
- Macro ID_WB_BYPASS_EN.
- Defined: when wb_en=1, wb_rd!=0 and wb_rd matches a read index in the same cycle, the read returns wb_data (write-through).
- Undefined: the read returns the pre-write register value; execute-stage forwarding must cover this case.

Test Plan:
- Reset: hold rst_n=0 with random inst_in -> all ex_* = 0, stall_out=0; after release, addi x1,x0,5 (0x00500093) -> ex_valid=1, ex_rd=1, ex_imm=5 two edges later.
- Immediates: sw x2,-4(x1) (0xFE20AE23) -> ex_imm=0xFFFFFFFC; beq x0,x0,-8 (0xFE000CE3) -> ex_imm=0xFFFFFFF8; lui x3,0x12345 (0x123451B7) -> ex_imm=0x12345000.
- Load-use: lw x5,0(x1) followed by add x6,x5,x2 -> stall_out=1 for exactly one cycle, one bubble (ex_valid=0), then add issues with ex_rs1=5; lw x0 followed by a use of x0 -> no stall.
- Flush: flush=1 while add sits in IF/ID and lw sits in ID/EX -> next cycle ex_valid=0, stall_out=0, no stall for the flushed pair.
- Writeback: wb_en=1, wb_rd=7, wb_data=0xDEADBEEF in the same cycle IF/ID reads x7 -> ex_rs1_data=0xDEADBEEF with ID_WB_BYPASS_EN, old value without; wb_rd=0 -> x0 still reads 0.
